// File: rtl/demux4_saidas_32bits_pkg.sv
// Shared types and sizes for the registered 1-to-4 demultiplexer.
package demux_pkg;
  localparam int LARGURA = 32;
  localparam int NSAIDAS = 4;

  typedef logic [1:0]         sel_t;
  typedef logic [LARGURA-1:0] palavra_t;

  // One-hot slot decode; every select value maps to exactly one slot.
  function automatic logic [NSAIDAS-1:0] decodifica(input sel_t s);
    logic [NSAIDAS-1:0] um;
    um = {{(NSAIDAS-1){1'b0}}, 1'b1};
    return um << s;
  endfunction
endpackage

// File: rtl/demux4_saidas_32bits_if.sv
// Producer/consumer bus of the demultiplexer: the master drives select, data and strobes,
// the slave (the demux) returns the slot contents and status.
interface demux4_saidas_32bits_if;
  import demux_pkg::*;

  sel_t               controlador;
  palavra_t           entrada;
  logic               escreve;
  logic [NSAIDAS-1:0] consome;
  palavra_t           saida0;
  palavra_t           saida1;
  palavra_t           saida2;
  palavra_t           saida3;
  logic [NSAIDAS-1:0] valido;
  logic               cheio;
  logic               erro;
  logic [7:0]         contador;

  modport master (
    output controlador, entrada, escreve, consome,
    input  saida0, saida1, saida2, saida3, valido, cheio, erro, contador
  );

  modport slave (
    input  controlador, entrada, escreve, consome,
    output saida0, saida1, saida2, saida3, valido, cheio, erro, contador
  );
endinterface

// File: rtl/demux4_saidas_32bits_registrador_slot.sv
// One holding slot: a data word plus a valid flag. A load always wins over a clear,
// so a same-cycle consume only retires the word being replaced.
module registrador_slot
  import demux_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     carrega,
  input  logic     limpa,
  input  palavra_t dado,
  output palavra_t q,
  output logic     valido
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      valido <= 1'b0;
    end else if (carrega) begin
      q      <= dado;
      valido <= 1'b1;
    end else if (limpa) begin
      valido <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_saidas_32bits.sv
// Registered 1-to-4 demultiplexer with per-slot valid/acknowledge and a write counter.
// Define DEMUX_PROTECT_EN to drop (and flag on erro) writes that would overwrite an unconsumed slot.
module demux4_saidas_32bits
  import demux_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  demux4_saidas_32bits_if.slave  bus
);

  logic [NSAIDAS-1:0] alvo;
  logic [NSAIDAS-1:0] bloqueado;
  logic [NSAIDAS-1:0] carrega;
  logic [NSAIDAS-1:0] valido;
  palavra_t           q [NSAIDAS];
  logic [7:0]         contador;

  assign alvo = bus.escreve ? decodifica(bus.controlador) : '0;

`ifdef DEMUX_PROTECT_EN
  // A live word is protected unless its consumer acknowledges it in the same cycle.
  assign bloqueado = alvo & valido & ~bus.consome;
`else
  assign bloqueado = '0;
`endif

  assign carrega = alvo & ~bloqueado;

  for (genvar i = 0; i < NSAIDAS; i++) begin : g_slot
    registrador_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .carrega (carrega[i]),
      .limpa   (bus.consome[i]),
      .dado    (bus.entrada),
      .q       (q[i]),
      .valido  (valido[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      contador <= 8'd0;
    end else if (|carrega) begin
      contador <= contador + 8'd1;
    end
  end

`ifdef DEMUX_PROTECT_EN
  logic erro;
  always_ff @(posedge clk) begin
    if (reset) begin
      erro <= 1'b0;
    end else begin
      erro <= |bloqueado;
    end
  end
`else
  logic erro;
  assign erro = 1'b0;
`endif

  assign bus.saida0   = q[0];
  assign bus.saida1   = q[1];
  assign bus.saida2   = q[2];
  assign bus.saida3   = q[3];
  assign bus.valido   = valido;
  assign bus.cheio    = &valido;
  assign bus.erro     = erro;
  assign bus.contador = contador;

endmodule

// File: tb/tb_demux4_saidas_32bits.sv
// Self-checking bench for demux4_saidas_32bits: array-based slot model checked every cycle,
// plus directed literal checks. Honours DEMUX_PROTECT_EN the same way the design does.
module tb_demux4_saidas_32bits;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  demux4_saidas_32bits_if bus ();

  demux4_saidas_32bits dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what each slot must hold, computed from the stated rules.
  logic [31:0] m_dado [4];
  logic        m_val  [4];
  int          m_cont;
  logic        m_erro;
  logic        m_ok = 1'b0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    tests++;
    if (atual !== esperado) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nome, atual, esperado, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_dado[i] = 32'd0;
        m_val[i]  = 1'b0;
      end
      m_cont = 0;
      m_erro = 1'b0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      logic [3:0] velho;
      int s;
      for (int i = 0; i < 4; i++) velho[i] = m_val[i];
      for (int i = 0; i < 4; i++) if (bus.consome[i]) m_val[i] = 1'b0;
      m_erro = 1'b0;
      if (bus.escreve) begin
        s = int'(bus.controlador);
`ifdef DEMUX_PROTECT_EN
        if (velho[s] && !bus.consome[s]) begin
          m_erro = 1'b1;
        end else begin
          m_dado[s] = bus.entrada;
          m_val[s]  = 1'b1;
          m_cont    = (m_cont + 1) % 256;
        end
`else
        m_dado[s] = bus.entrada;
        m_val[s]  = 1'b1;
        m_cont    = (m_cont + 1) % 256;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_val[i];
      chk("model saida0", bus.saida0, m_dado[0]);
      chk("model saida1", bus.saida1, m_dado[1]);
      chk("model saida2", bus.saida2, m_dado[2]);
      chk("model saida3", bus.saida3, m_dado[3]);
      chk("model valido", {28'd0, bus.valido}, {28'd0, v});
      chk("model cheio", {31'd0, bus.cheio}, {31'd0, &v});
      chk("model erro", {31'd0, bus.erro}, {31'd0, m_erro});
      chk("model contador", {24'd0, bus.contador}, m_cont[31:0]);
    end
  end

  // Apply one cycle of inputs from a falling edge; return at the next falling edge.
  task automatic step(input logic r, input logic esc, input logic [1:0] ctrl,
                      input logic [31:0] dado, input logic [3:0] cons);
    reset           = r;
    bus.escreve     = esc;
    bus.controlador = ctrl;
    bus.entrada     = dado;
    bus.consome     = cons;
    @(negedge clk);
  endtask

  initial begin
    step(1'b1, 1'b1, 2'd1, 32'h1234_5678, 4'b0000);
    step(1'b1, 1'b0, 2'd0, 32'd0, 4'b0000);
    step(1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
    chk("reset valido", {28'd0, bus.valido}, 32'd0);
    chk("reset contador", {24'd0, bus.contador}, 32'd0);
    chk("reset erro", {31'd0, bus.erro}, 32'd0);
    chk("reset saida1", bus.saida1, 32'd0);

    step(1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
    chk("write slot2 data", bus.saida2, 32'hDEAD_BEEF);
    chk("write slot2 valido", {28'd0, bus.valido}, 32'h4);
    step(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFF, 4'b0100);
    chk("consume slot2 valido", {28'd0, bus.valido}, 32'h0);
    chk("consume keeps data", bus.saida2, 32'hDEAD_BEEF);

    step(1'b1, 1'b0, 2'd0, 32'd0, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 32'(i + 1), 4'b0000);
    chk("fill cheio", {31'd0, bus.cheio}, 32'd1);
    chk("fill contador", {24'd0, bus.contador}, 32'd4);
    chk("fill saida3", bus.saida3, 32'd4);

    step(1'b0, 1'b1, 2'd1, 32'h55, 4'b0010);
    chk("write+consume saida1", bus.saida1, 32'h55);
    chk("write+consume valido1", {31'd0, bus.valido[1]}, 32'd1);
    chk("write+consume erro", {31'd0, bus.erro}, 32'd0);

    step(1'b0, 1'b1, 2'd3, 32'hA, 4'b1000);
    chk("slot3 holds A", bus.saida3, 32'hA);
    chk("contador before overwrite", {24'd0, bus.contador}, 32'd6);
    step(1'b0, 1'b1, 2'd3, 32'hB, 4'b0000);
`ifdef DEMUX_PROTECT_EN
    chk("protected saida3", bus.saida3, 32'hA);
    chk("protected erro", {31'd0, bus.erro}, 32'd1);
    chk("protected contador", {24'd0, bus.contador}, 32'd6);
    step(1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
    chk("erro single pulse", {31'd0, bus.erro}, 32'd0);
`else
    chk("overwrite saida3", bus.saida3, 32'hB);
    chk("overwrite erro", {31'd0, bus.erro}, 32'd0);
    chk("overwrite contador", {24'd0, bus.contador}, 32'd7);
    step(1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);
    chk("erro stays low", {31'd0, bus.erro}, 32'd0);
`endif

    step(1'b0, 1'b0, 2'd0, 32'd0, 4'b1111);
    chk("multi consume valido", {28'd0, bus.valido}, 32'd0);
    step(1'b0, 1'b0, 2'd2, 32'd0, 4'b1111);
    chk("consume invalid valido", {28'd0, bus.valido}, 32'd0);
    chk("consume invalid erro", {31'd0, bus.erro}, 32'd0);

    step(1'b1, 1'b0, 2'd0, 32'd0, 4'b0000);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 2'(i % 4), 32'hC000_0000 + 32'(i), 4'(1 << (i % 4)));
      if (i == 254) chk("contador at 255", {24'd0, bus.contador}, 32'd255);
    end
    chk("contador wraps", {24'd0, bus.contador}, 32'd0);
    chk("wrap last word", bus.saida3, 32'hC000_00FF);
    step(1'b1, 1'b1, 2'd0, 32'h7777_7777, 4'b0000);
    chk("mid-stream reset saida0", bus.saida0, 32'd0);
    chk("mid-stream reset valido", {28'd0, bus.valido}, 32'd0);
    chk("mid-stream reset contador", {24'd0, bus.contador}, 32'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/demux4_saidas_32bits.md
# demux4_saidas_32bits

Registered 1-to-4 demultiplexer for the multicycle datapath. It performs the inverse of the 4-input 32-bit selection mux: one 32-bit source word is steered, on a write strobe, into one of four holding registers chosen by a 2-bit select. Each slot carries a valid flag that its consumer clears with a per-slot acknowledge. The block sits between a single producer, such as the ALU result or memory data register, and four consumers that need the value to persist across cycles.

## Interface
Parameters:
- LARGURA, 32, width of data word and of each slot
- NSAIDAS, 4, number of slots (fixed at 4; select is 2 bits)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- controlador  input  2  destination slot select, sampled when escreve=1
- entrada  input  32  data word to store
- escreve  input  1  write strobe
- consome  input  4  per-slot acknowledge; bit i clears slot i valid
- saida0..saida3  output  32 each  registered slot contents
- valido  output  4  per-slot valid flags
- cheio  output  1  combinational AND of valido
- erro  output  1  one-cycle pulse on a rejected write (see Configuration)
- contador  output  8  count of accepted writes, wraps 255→0

## Operation
- Reset (reset=1 at rising edge):
  - saida0..3 = 0, valido = 4'b0000, erro = 0, contador = 0.
  - Reset overrides escreve/consome in the same cycle.
- Accepted write (escreve=1, slot N=controlador):
  - saidaN ← entrada; valido[N] ← 1; contador ← contador+1.
  - Other slots hold.
- Consume: consome[i]=1 with valido[i]=1 → valido[i] ← 0. saida_i keeps its data.
  - Consume on an invalid slot is ignored, with no error.
- Simultaneous write and consume on the same slot → write wins: new data loaded, valido stays 1. The consume applies to the old word.
- Simultaneous consumes on several slots are all honoured in one cycle.
- Write to a slot with valido=1 and no same-cycle consume: behaviour per Configuration.
- controlador is ignored when escreve=0.
- No X propagation: every select value maps to a slot.

## Timing
- Write latency 1 cycle: data presented at edge k appears on saidaN and valido[N] after edge k.
- Consume latency 1 cycle.
- cheio is combinational from registered valido, so it is effectively registered.
- erro is high for exactly the cycle following the offending edge.
- Back-to-back writes every cycle are supported, including repeated writes to the same slot.
- contador updates in the same edge as the accepted write.

## Configuration
- DEMUX_PROTECT_EN defined:
  - A write to a slot with valido=1 and no same-cycle consume on that slot is dropped.
  - The slot keeps its old data, contador does not increment, and erro pulses 1 for one cycle.
- DEMUX_PROTECT_EN undefined:
  - Such a write overwrites the slot and counts as accepted.
  - erro is tied to 0.

## Structure
- Shared package demux_pkg holds:
  - localparam LARGURA=32 and NSAIDAS=4
  - typedef sel_t (logic [1:0]) and typedef palavra_t (logic [31:0])
- One natural sub-module, registrador_slot, instantiated 4 times. It holds a 32-bit data register and a valid flag, with inputs clk, reset, carrega, limpa, and dado.
- The top level decodes controlador/escreve into four carrega strings and owns erro, contador, and cheio.

## Test plan
- Reset held 2 cycles, then released → all saida=0, valido=0000, contador=0, erro=0.
- Write 0xDEADBEEF to slot 2, then consome=0100 next cycle → saida2=0xDEADBEEF with valido=0100 after one edge. After the second edge valido=0000 and saida2 still 0xDEADBEEF.
- Writes 0x1,0x2,0x3,0x4 to slots 0..3 on consecutive cycles → cheio=1 after the 4th edge, contador=4.
- Slot 1 valid; write 0x55 to slot 1 with consome=0010 in the same cycle → saida1=0x55, valido[1]=1, erro=0.
- Slot 3 holds 0xA; write 0xB to slot 3 without consume:
  - With DEMUX_PROTECT_EN → saida3=0xA, erro pulses once, contador unchanged.
  - Without it → saida3=0xB, erro=0, contador+1.
- 256 consecutive writes followed by reset asserted mid-stream → contador wraps to 0 at the 256th write; reset clears all state on the next edge despite escreve=1.
